// File: rtl/strassen_pkg.sv
// Shared definitions for the Strassen accelerator result path: default sizes,
// writer state encoding and the quadrant numbering of the result stream.
package strassen_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int N_DEF          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } wb_state_t;

    // Bit 1 selects the lower half of rows, bit 0 the right half of columns.
    typedef enum logic [1:0] {
        Q_C11 = 2'd0,
        Q_C12 = 2'd1,
        Q_C21 = 2'd2,
        Q_C22 = 2'd3
    } quadrant_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding {data, addr} words for the result writer.
// The read port shows zero while empty so downstream outputs have clean idle values.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_slot_s;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Accept decisions; a flush empties the buffer so a same-cycle push always fits
    always_comb begin
        push_ok_s = push && (flush || (count_r != FULL_COUNT));
        pop_ok_s  = pop && !flush && (count_r != {CW{1'b0}});
        if (flush) begin
            wr_slot_s = {PW{1'b0}};
        end else begin
            wr_slot_s = wr_ptr_r;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= push_ok_s ? PW'(1) : PW'(0);
            count_r  <= push_ok_s ? CW'(1) : CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; no reset needed because the read port is masked while empty
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_slot_s] <= wdata;
    end

    // Head-of-queue read port
    always_comb begin
        if (count_r == {CW{1'b0}}) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    assign full  = (count_r == FULL_COUNT);
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/c_writeback.sv
// Result writer: buffers the quadrant-ordered C stream, remaps each element to a
// row-major address at push time and writes it out under a ready/valid handshake.
module c_writeback
    import strassen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = N_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = $clog2(N*N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] c_in,
    input  logic                  write_en,
    input  logic                  load_out,
    input  logic                  finished,
    input  logic                  mem_ready,
    output logic                  full,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  done,
    output logic                  incomplete,
    output logic                  overflow
);
    localparam int NN = N * N;
    localparam int KW = $clog2(NN) + 1;
    localparam int LH = $clog2(N / 2);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [KW-1:0] K_LAST  = KW'(NN - 1);
    localparam logic [KW-1:0] K_TOTAL = KW'(NN);

    wb_state_t             state_r;
    logic [KW-1:0]         k_r;
    logic [KW-1:0]         written_r;
    logic [KW-1:0]         written_next_s;
    logic [KW-2:0]         k_idx_s;
    logic                  done_r;
    logic                  incomplete_r;
    logic                  overflow_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  last_push_s;
    logic                  drained_s;
    quadrant_t             quad_s;
    logic [ADDR_WIDTH-1:0] push_addr_s;
    logic [FW-1:0]         fifo_rdata_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;

    // Index used for address generation; a load_out restarts the matrix at k=0
    always_comb begin
        if (load_out) begin
            k_idx_s = {(KW-1){1'b0}};
        end else begin
            k_idx_s = k_r[KW-2:0];
        end
    end

    assign quad_s = quadrant_t'(k_idx_s[2*LH+1:2*LH]);

    // Quadrant bits become the top bit of row and column; the rest are direct slices
    generate
        if (LH == 0) begin : g_addr_n2
            assign push_addr_s = {quad_s[1], quad_s[0]};
        end else begin : g_addr
            assign push_addr_s = {quad_s[1], k_idx_s[2*LH-1:LH], quad_s[0], k_idx_s[LH-1:0]};
        end
    endgenerate

    // Per-cycle push, drop and retire decisions
    always_comb begin
        pop_s  = !fifo_empty_s && mem_ready && !load_out;
        push_s = 1'b0;
        drop_s = 1'b0;
        if (load_out) begin
            push_s = write_en;
        end else if (state_r == ST_COLLECT) begin
            push_s = write_en && !fifo_full_s;
            drop_s = write_en && fifo_full_s;
        end else if (state_r == ST_DRAIN) begin
            drop_s = write_en && fifo_full_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        last_push_s = push_s && !load_out && (k_r == K_LAST);
        // FIFO will be empty after this edge, so the matrix is complete
        drained_s = !push_s && (fifo_empty_s || ((fifo_count_s == CW'(1)) && pop_s));
        if (pop_s) begin
            written_next_s = written_r + KW'(1);
        end else begin
            written_next_s = written_r;
        end
    end

    // Writer FSM with push/write counters and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            k_r          <= {KW{1'b0}};
            written_r    <= {KW{1'b0}};
            done_r       <= 1'b0;
            incomplete_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (load_out) begin
            state_r      <= ST_COLLECT;
            k_r          <= push_s ? KW'(1) : KW'(0);
            written_r    <= {KW{1'b0}};
            done_r       <= 1'b0;
            incomplete_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            written_r <= written_next_s;
            if (push_s) k_r <= k_r + KW'(1);
            if (drop_s) overflow_r <= 1'b1;
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_COLLECT: begin
                    // finished with nothing left to write skips DRAIN so done is not delayed
                    if (finished && drained_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        if (written_next_s < K_TOTAL) incomplete_r <= 1'b1;
                    end else if (finished || last_push_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        if (written_next_s < K_TOTAL) incomplete_r <= 1'b1;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (load_out),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({c_in, push_addr_s}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign full       = fifo_full_s;
    assign mem_we     = !fifo_empty_s;
    assign mem_addr   = fifo_rdata_s[ADDR_WIDTH-1:0];
    assign mem_data   = fifo_rdata_s[FW-1:ADDR_WIDTH];
    assign done       = done_r;
    assign incomplete = incomplete_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_c_writeback.sv
// Directed bench for c_writeback (N=4, FIFO_DEPTH=4).
module tb_c_writeback;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] c_in = '0;
    logic          write_en = 1'b0;
    logic          load_out = 1'b0;
    logic          finished = 1'b0;
    logic          mem_ready = 1'b0;
    logic          full;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          done;
    logic          incomplete;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Row-major address expected for quadrant-ordered push index k
    int exp_addr [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    // Observed memory traffic
    int wr_addr_q [$];
    int wr_data_q [$];
    int cyc = 0;
    int last_acc_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int full_cnt = 0;

    c_writeback #(.DATA_WIDTH(DW), .N(4), .FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .c_in(c_in), .write_en(write_en), .load_out(load_out),
        .finished(finished), .mem_ready(mem_ready), .full(full), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .done(done), .incomplete(incomplete),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mem_we && mem_ready) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_data));
            last_acc_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (full) full_cnt <= full_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL %s_done_timeout: done not seen within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; write_en = 1'b0; load_out = 1'b0; finished = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 4'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_data !== 16'd0) begin errors++; $display("FAIL reset_mem_data: got %0d want 0", mem_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (incomplete !== 1'b0) begin errors++; $display("FAIL reset_incomplete: got %b want 0", incomplete); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        // write_en in IDLE is ignored
        write_en = 1'b1; c_in = 16'h00EE;
        repeat (2) @(negedge clk);
        write_en = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: mem_we=%b overflow=%b want 0 0", mem_we, overflow);
        end
    endtask

    task automatic test_full_matrix();
        int base_wr, base_done, base_full;
        base_wr = wr_addr_q.size(); base_done = done_cnt; base_full = full_cnt;
        mem_ready = 1'b1; load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fm_load_we: got %b want 0", mem_we); end
        for (int k = 0; k < 16; k++) begin
            write_en = 1'b1; c_in = DW'(k);
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(exp_addr[k]) || mem_data !== DW'(k)) begin
                errors++;
                $display("FAIL fm_head k=%0d: we=%b addr=%0d data=%0d want 1 %0d %0d", k, mem_we, mem_addr, mem_data, exp_addr[k], k);
            end
        end
        write_en = 1'b0;
        wait_done(base_done, "fm");
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() - base_wr != 16) begin
            errors++; $display("FAIL fm_count: got %0d writes want 16", wr_addr_q.size() - base_wr);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_addr_q[base_wr+i] != exp_addr[i] || wr_data_q[base_wr+i] != i) begin
                    errors++;
                    $display("FAIL fm_write %0d: addr=%0d data=%0d want %0d %0d", i, wr_addr_q[base_wr+i], wr_data_q[base_wr+i], exp_addr[i], i);
                end
            end
        end
        checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL fm_done_pulses: got %0d want 1", done_cnt - base_done); end
        checks++; if (done_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL fm_done_timing: done cycle %0d want %0d", done_cyc, last_acc_cyc + 1); end
        checks++; if (incomplete !== 1'b0) begin errors++; $display("FAIL fm_incomplete: got %b want 0", incomplete); end
        checks++; if (full_cnt != base_full) begin errors++; $display("FAIL fm_full_seen: full high %0d cycles want 0", full_cnt - base_full); end
    endtask

    task automatic test_backpressure();
        int base_wr, base_done;
        base_wr = wr_addr_q.size(); base_done = done_cnt;
        mem_ready = 1'b0; load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
            write_en = 1'b1; c_in = DW'(16'h00A0 + k);
            @(negedge clk);
            checks++;
            if (full !== (k == 3)) begin errors++; $display("FAIL bp_full after %0d pushes: got %b want %b", k + 1, full, (k == 3)); end
        end
        c_in = 16'hBAD0;
        @(negedge clk);
        write_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_data !== 16'h00A0) begin
                errors++; $display("FAIL bp_stable %0d: we=%b addr=%0d data=%h want 1 0 00a0", i, mem_we, mem_addr, mem_data);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1; finished = 1'b1;
        @(negedge clk);
        finished = 1'b0;
        wait_done(base_done, "bp");
        checks++;
        if (wr_addr_q.size() - base_wr != 4) begin
            errors++; $display("FAIL bp_count: got %0d writes want 4", wr_addr_q.size() - base_wr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_q[base_wr+i] != exp_addr[i] || wr_data_q[base_wr+i] != 16'h00A0 + i) begin
                    errors++; $display("FAIL bp_write %0d: addr=%0d data=%h", i, wr_addr_q[base_wr+i], wr_data_q[base_wr+i]);
                end
            end
        end
        checks++; if (incomplete !== 1'b1) begin errors++; $display("FAIL bp_incomplete: got %b want 1", incomplete); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_short_matrix();
        int base_wr, base_done;
        base_wr = wr_addr_q.size(); base_done = done_cnt;
        mem_ready = 1'b1; load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
        for (int k = 0; k < 9; k++) begin
            write_en = 1'b1; c_in = DW'(k);
            @(negedge clk);
        end
        write_en = 1'b0; finished = 1'b1;
        @(negedge clk);
        finished = 1'b0;
        wait_done(base_done, "sm");
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr_q.size() - base_wr != 9) begin
            errors++; $display("FAIL sm_count: got %0d writes want 9", wr_addr_q.size() - base_wr);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wr_addr_q[base_wr+i] != exp_addr[i] || wr_data_q[base_wr+i] != i) begin
                    errors++; $display("FAIL sm_write %0d: addr=%0d data=%0d want %0d %0d", i, wr_addr_q[base_wr+i], wr_data_q[base_wr+i], exp_addr[i], i);
                end
            end
        end
        checks++; if (done_cnt - base_done != 1) begin errors++; $display("FAIL sm_done_pulses: got %0d want 1", done_cnt - base_done); end
        checks++; if (done_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL sm_done_timing: done cycle %0d want %0d", done_cyc, last_acc_cyc + 1); end
        checks++; if (incomplete !== 1'b1) begin errors++; $display("FAIL sm_incomplete: got %b want 1", incomplete); end
    endtask

    task automatic test_load_flush();
        int base_wr, base_done;
        mem_ready = 1'b0; load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            write_en = 1'b1; c_in = DW'(16'h0050 + k);
            @(negedge clk);
        end
        write_en = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++; if (overflow !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL lf_pre: overflow=%b we=%b want 1 1", overflow, mem_we); end
        base_wr = wr_addr_q.size(); base_done = done_cnt;
        load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lf_flush_we: got %b want 0", mem_we); end
        checks++; if (overflow !== 1'b0 || incomplete !== 1'b0) begin errors++; $display("FAIL lf_flags: overflow=%b incomplete=%b want 0 0", overflow, incomplete); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL lf_full: got %b want 0", full); end
        mem_ready = 1'b1; write_en = 1'b1; c_in = 16'h0077;
        @(negedge clk);
        write_en = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd0 || mem_data !== 16'h0077) begin
            errors++; $display("FAIL lf_first: we=%b addr=%0d data=%h want 1 0 0077", mem_we, mem_addr, mem_data);
        end
        finished = 1'b1;
        @(negedge clk);
        finished = 1'b0;
        wait_done(base_done, "lf");
        checks++;
        if (wr_addr_q.size() - base_wr != 1) begin
            errors++; $display("FAIL lf_count: got %0d writes want 1", wr_addr_q.size() - base_wr);
        end else if (wr_addr_q[base_wr] != 0 || wr_data_q[base_wr] != 16'h0077) begin
            errors++; $display("FAIL lf_write: addr=%0d data=%h want 0 0077", wr_addr_q[base_wr], wr_data_q[base_wr]);
        end
    endtask

    task automatic test_reset_in_drain();
        int base_wr, base_done;
        mem_ready = 1'b0; load_out = 1'b1;
        @(negedge clk);
        load_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            write_en = 1'b1; c_in = DW'(16'h0060 + k);
            @(negedge clk);
        end
        write_en = 1'b0; finished = 1'b1;
        @(negedge clk);
        finished = 1'b0;
        base_wr = wr_addr_q.size(); base_done = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({full, mem_we, mem_addr, mem_data, done, incomplete, overflow} !== 25'd0) begin
            errors++;
            $display("FAIL rd_reset: full=%b we=%b addr=%0d data=%h done=%b inc=%b ovf=%b want all 0", full, mem_we, mem_addr, mem_data, done, incomplete, overflow);
        end
        rst = 1'b0; mem_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (wr_addr_q.size() != base_wr) begin errors++; $display("FAIL rd_no_write: got %0d writes want 0", wr_addr_q.size() - base_wr); end
        checks++; if (mem_we !== 1'b0 || done_cnt != base_done) begin errors++; $display("FAIL rd_quiet: we=%b done pulses=%0d want 0 0", mem_we, done_cnt - base_done); end
    endtask

    task automatic test_back_to_back();
        int base_wr, base_done;
        int e_addr [5] = '{0, 1, 4, 5, 2};
        base_wr = wr_addr_q.size(); base_done = done_cnt;
        mem_ready = 1'b0; load_out = 1'b1; write_en = 1'b1; c_in = 16'h0010;
        @(negedge clk);
        load_out = 1'b0; c_in = 16'h0011;
        @(negedge clk);
        checks++;
        if (mem_addr !== 4'd0 || mem_data !== 16'h0010 || full !== 1'b0) begin
            errors++; $display("FAIL bb_head0: addr=%0d data=%h full=%b want 0 0010 0", mem_addr, mem_data, full);
        end
        mem_ready = 1'b1; c_in = 16'h0012;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_data !== 16'h0011) begin
            errors++; $display("FAIL bb_head1: we=%b addr=%0d data=%h want 1 1 0011", mem_we, mem_addr, mem_data);
        end
        c_in = 16'h0013;
        @(negedge clk);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL bb_full3: got %b want 0", full); end
        c_in = 16'h0014;
        @(negedge clk);
        write_en = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL bb_full4: got %b want 1", full); end
        mem_ready = 1'b1; finished = 1'b1;
        @(negedge clk);
        finished = 1'b0;
        wait_done(base_done, "bb");
        checks++;
        if (wr_addr_q.size() - base_wr != 5) begin
            errors++; $display("FAIL bb_count: got %0d writes want 5", wr_addr_q.size() - base_wr);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_addr_q[base_wr+i] != e_addr[i] || wr_data_q[base_wr+i] != 16'h0010 + i) begin
                    errors++; $display("FAIL bb_write %0d: addr=%0d data=%h want %0d %h", i, wr_addr_q[base_wr+i], wr_data_q[base_wr+i], e_addr[i], 16'h0010 + i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_matrix();
        test_backpressure();
        test_short_matrix();
        test_load_flush();
        test_reset_in_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_writeback.md
# c_writeback

Downstream result stage of the Strassen accelerator. Consumes the `C_out` / `Write_en` element stream produced by the top-level compute core and buffers it in a small FIFO. Remaps quadrant-ordered results (C11, C12, C21, C22) into row-major result-memory addresses and writes them to the result RAM under a ready/valid backpressure handshake. Signals completion of one N×N result matrix.

## Interface
- `DATA_WIDTH`, default 16: element width, identical to the core's `C_out` width.
- `N`, default 4: matrix dimension. Must be a power of two and at least 2.
- `FIFO_DEPTH`, default 4: buffer entries. Must be a power of two.
- `ADDR_WIDTH`, default `$clog2(N*N)`: result-memory address width.
- `clk`  in  1  single clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `c_in`  in  DATA_WIDTH  result element from the core (`C_out`).
- `write_en`  in  1  `c_in` is valid this cycle (core `Write_en`).
- `load_out`  in  1  start of a new result matrix (core `load_out`). Single-cycle pulse.
- `finished`  in  1  core has produced its last element. Single-cycle pulse.
- `mem_ready`  in  1  result RAM accepts the current write.
- `full`  out  1  FIFO full. The core must stall.
- `mem_we`  out  1  write request valid.
- `mem_addr`  out  ADDR_WIDTH  row-major address.
- `mem_data`  out  DATA_WIDTH  write data.
- `done`  out  1  one-cycle pulse when the matrix is fully written.
- `incomplete`  out  1  sticky. Drain ended with fewer than N*N elements written.
- `overflow`  out  1  sticky. A `write_en` arrived while `full` and the element was dropped.

## Operation
- States:
  - IDLE → COLLECT on `load_out`.
  - COLLECT → DRAIN on `finished`, or when N*N elements have been pushed.
  - DRAIN → DONE when the FIFO is empty and no write is pending.
  - DONE → IDLE unconditionally after one cycle. `done` is high only in DONE.
- `load_out` in any state has priority:
  - flushes the FIFO and drops any pending `mem_we`;
  - clears the push counter `k`, `incomplete` and `overflow`;
  - moves the state to COLLECT.
  - A `write_en` in the same cycle is accepted as element k=0.
- `write_en` outside COLLECT/DRAIN is ignored and does not set `overflow`.
- Push: `write_en && !full` in COLLECT stores `{c_in, addr(k)}` and increments `k`.
- `write_en && full` drops the element, sets `overflow`, and does not increment `k`.
- `full` is computed from the registered count. A push at full is dropped even when a pop occurs in the same cycle.
- Address map, with H = N/2, k = push index 0..N*N-1:
  - q = k[2·log2(H)+1 : 2·log2(H)];
  - r = k / H mod H, c = k mod H;
  - row = r + q[1]·H, col = c + q[0]·H;
  - addr = row·N + col.
  - All terms are pure bit-slices and concatenation, with no multiplier.
  - Addresses are computed at push time and stored with the data.
- Pop: the FIFO head drives `mem_data` / `mem_addr` with `mem_we`=1. The entry retires on `mem_we && mem_ready`.
- `mem_we`, `mem_addr` and `mem_data` are held stable until accepted.
- On the DRAIN → DONE transition, `incomplete` is set if the total written count is less than N*N.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits wide.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.

## Timing
- Reset values:
  - state IDLE, FIFO empty, `k`=0;
  - `full`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0;
  - `done`=0, `incomplete`=0, `overflow`=0.
- `rst` mid-operation discards all buffered data, with no memory write issued.
- Latency: an element pushed in cycle t presents `mem_we`=1 at cycle t+1 at the earliest (registered FIFO output).
- With `mem_ready` held at 1, throughput is one element per cycle and `full` never asserts.
- `done` asserts exactly one cycle after the cycle in which the last entry is accepted (`mem_we && mem_ready`), and lasts one cycle.
- `full` updates one cycle after the push or pop that changes the count.

## Structure
- A shared package `strassen_pkg` holds:
  - `DATA_WIDTH` and the `N` defaults;
  - the writer state enum (IDLE, COLLECT, DRAIN, DONE);
  - the quadrant encoding (C11=0, C12=1, C21=2, C22=3).
- One sub-module, `sync_fifo`: parameterised width and depth, with push, pop, full, empty, count. It stores the {data, addr} word.
- Address remap and FSM are inline in `c_writeback`.

## Test plan
- N=4, `mem_ready`=1, `load_out` then 16 `write_en` with c_in=k → memory writes in this order:
  - addr 0,1,4,5 (C11), then 2,3,6,7 (C12), then 8,9,12,13 (C21), then 10,11,14,15 (C22);
  - k=6 lands at addr 6 and k=15 at addr 15;
  - `done` pulses once, `incomplete`=0.
- `mem_ready`=0 for 10 cycles during a stream → `full`=1 after 4 pushes and `mem_we`/`mem_addr`/`mem_data` stay stable. A fifth `write_en` sets `overflow`=1 and that element is never written.
- `finished` after 9 elements → 9 writes complete, `done` pulses, `incomplete`=1.
- `load_out` asserted mid-matrix with 3 entries buffered and `mem_ready`=0 → FIFO flushed, `mem_we`=0 next cycle, the next element written to addr 0, `overflow`/`incomplete` cleared.
- `rst` asserted during DRAIN → all outputs return to their reset values the next cycle and no further `mem_we` appears.
- Push and pop in the same cycle at count=2 → count stays 2 and the address order is preserved.
